// File: rtl/inj_ctrl_pkg.sv
// Shared widths, valid-bit position, FSM encoding and defaults for the local injection controller.
package inj_ctrl_pkg;

  localparam int WIDTH_PORT       = 32;
  localparam int WIDTH_PV         = 5;
  localparam int POS_VALID        = WIDTH_PORT - 1;
  localparam int STARVE_LIMIT_DEF = 16;

  typedef enum logic [1:0] {
    INJ_IDLE    = 2'd0,
    INJ_WAIT    = 2'd1,
    INJ_STARVED = 2'd2
  } injState_t;

  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inj_ctrl_if.sv
// PE-side and router-side signals of the injection controller.
// Optional statistics outputs exist only when INJ_CTRL_STATS_EN is defined.
interface inj_ctrl_if #(
  parameter int FLIT_W = inj_ctrl_pkg::WIDTH_PORT,
  parameter int PV_W   = inj_ctrl_pkg::WIDTH_PV,
  parameter int DEPTH  = 4
) ();
  localparam int CNT_W = inj_ctrl_pkg::cntWidth(DEPTH);

  logic [FLIT_W-1:0] pe_flit;
  logic [PV_W-1:0]   pe_pv;
  logic              pe_valid;
  logic              pe_ready;
  logic              slot_free;
  logic [FLIT_W-1:0] dout_local;
  logic [PV_W-1:0]   pv_local;
  logic              starve_req;
  logic [CNT_W-1:0]  fifo_cnt;
`ifdef INJ_CTRL_STATS_EN
  logic [15:0]       stat_inj;
  logic [15:0]       stat_stall;
`endif

  modport master (
    output pe_flit, pe_pv, pe_valid, slot_free,
    input  pe_ready, dout_local, pv_local, starve_req, fifo_cnt
`ifdef INJ_CTRL_STATS_EN
    , input stat_inj, stat_stall
`endif
  );

  modport slave (
    input  pe_flit, pe_pv, pe_valid, slot_free,
    output pe_ready, dout_local, pv_local, starve_req, fifo_cnt
`ifdef INJ_CTRL_STATS_EN
    , output stat_inj, stat_stall
`endif
  );

endinterface

// File: rtl/inj_ctrl_fifo.sv
// Synchronous FIFO holding {flit, PV} entries; push is refused when full even if a pop
// happens in the same cycle. Storage is not reset, only the pointers and count.
module inj_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] cnt;
  logic          doPush, doPop;

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = mem[rdPtr];
  assign count  = cnt;

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/inj_ctrl.sv
// Local injection controller: buffers PE flits, injects one per free router slot, flags starvation.
// Define INJ_CTRL_STATS_EN to add the stat_inj / stat_stall saturating counters.
module inj_ctrl
  import inj_ctrl_pkg::*;
#(
  parameter int FLIT_W       = WIDTH_PORT,
  parameter int PV_W         = WIDTH_PV,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic       clk,
  input logic       reset,
  inj_ctrl_if.slave bus
);
  localparam int CNT_W   = cntWidth(DEPTH);
  localparam int ENTRY_W = FLIT_W + PV_W;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ENTRY_W-1:0] headEntry;
  logic               fifoFull, fifoEmpty;
  logic [CNT_W-1:0]   fifoCount, cntNext;
  logic               pushEn, popEn, starveHit;
  logic [FLIT_W-1:0]  injFlit;
  logic [FLIT_W-1:0]  doutLocal;
  logic [PV_W-1:0]    pvLocal;
  logic               starveReq;
  injState_t          state, stateNext;
  logic [7:0]         starveCnt, starveCntNext;

  assign pushEn    = bus.pe_valid & ~fifoFull;
  assign popEn     = ~fifoEmpty & bus.slot_free;
  assign cntNext   = fifoCount + CNT_W'(pushEn) - CNT_W'(popEn);
  assign starveHit = ({1'b0, starveCnt} + 9'd1) >= 9'(STARVE_LIMIT - 1);

  inj_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) uFifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (pushEn),
    .pop   (popEn),
    .din   ({bus.pe_flit, bus.pe_pv}),
    .dout  (headEntry),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_comb begin
    injFlit            = headEntry[ENTRY_W-1 -: FLIT_W];
    injFlit[POS_VALID] = 1'b1;
  end

  always_comb begin
    stateNext     = state;
    starveCntNext = starveCnt;
    case (state)
      INJ_IDLE: begin
        if (cntNext != '0) stateNext = INJ_WAIT;
      end
      INJ_WAIT: begin
        if (popEn) begin
          starveCntNext = '0;
          if (cntNext == '0) stateNext = INJ_IDLE;
        end else begin
          starveCntNext = satInc8(starveCnt);
          if (starveHit) stateNext = INJ_STARVED;
        end
      end
      INJ_STARVED: begin
        if (popEn) begin
          starveCntNext = '0;
          stateNext     = (cntNext == '0) ? INJ_IDLE : INJ_WAIT;
        end
      end
      default: begin
        stateNext     = INJ_IDLE;
        starveCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= INJ_IDLE;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      starveCnt <= starveCntNext;
    end
  end

  // Output registers: a flit is presented for exactly one cycle, zeros otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      doutLocal <= '0;
      pvLocal   <= '0;
      starveReq <= 1'b0;
    end else begin
      doutLocal <= popEn ? injFlit : '0;
      pvLocal   <= popEn ? headEntry[PV_W-1:0] : '0;
      starveReq <= (state == INJ_STARVED) && !popEn;
    end
  end

  assign bus.pe_ready   = ~fifoFull;
  assign bus.dout_local = doutLocal;
  assign bus.pv_local   = pvLocal;
  assign bus.starve_req = starveReq;
  assign bus.fifo_cnt   = fifoCount;

`ifdef INJ_CTRL_STATS_EN
  logic [15:0] statInj, statStall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      statInj   <= '0;
      statStall <= '0;
    end else begin
      if (popEn) statInj <= satInc16(statInj);
      if ((state != INJ_IDLE) && !bus.slot_free) statStall <= satInc16(statStall);
    end
  end

  assign bus.stat_inj   = statInj;
  assign bus.stat_stall = statStall;
`else
  // Core-only build: no statistics counters.
`endif

endmodule

// File: tb/tb_inj_ctrl.sv
// Self-checking bench for inj_ctrl against a queue-based reference model.
module tb_inj_ctrl;
  import inj_ctrl_pkg::*;

  localparam int FW  = WIDTH_PORT;
  localparam int PW  = WIDTH_PV;
  localparam int D   = 4;
  localparam int LIM = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inj_ctrl_if #(.FLIT_W(FW), .PV_W(PW), .DEPTH(D)) ifc ();

  inj_ctrl #(.FLIT_W(FW), .PV_W(PW), .DEPTH(D), .STARVE_LIMIT(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state
  logic [FW+PW-1:0] mq[$];
  logic [FW-1:0]    expDout;
  logic [PW-1:0]    expPv;
  logic             expStarve;
  int               streak;
  int               mInj, mStall;

  function automatic logic [FW-1:0] randFlit();
    logic [FW-1:0] f;
    f = FW'($urandom);
    f[POS_VALID] = 1'b1;
    return f;
  endfunction

  task automatic modelClear();
    mq.delete();
    expDout = '0; expPv = '0; expStarve = 1'b0;
    streak = 0; mInj = 0; mStall = 0;
  endtask

  // Advance model using the inputs currently applied, then clock the DUT.
  task automatic tick();
    int c;
    bit doPush, doPop;
    logic [FW-1:0] f;
    logic [PW-1:0] p;
    c      = mq.size();
    doPush = ifc.pe_valid && (c != D);
    doPop  = (c != 0) && ifc.slot_free;
    if (doPop) begin
      {f, p} = mq.pop_front();
      expDout = f;
      expDout[POS_VALID] = 1'b1;
      expPv = p;
      if (mInj < 65535) mInj++;
    end else begin
      expDout = '0;
      expPv   = '0;
    end
    if (c != 0 && !ifc.slot_free && mStall < 65535) mStall++;
    if (c == 0 || doPop) streak = 0;
    else streak++;
    expStarve = (c != 0) && !doPop && (streak >= LIM);
    if (doPush) mq.push_back({ifc.pe_flit, ifc.pe_pv});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifc.pe_valid = 0; ifc.slot_free = 0; ifc.pe_flit = '0; ifc.pe_pv = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++; if (ifc.dout_local !== '0) begin nErrors++; $display("FAIL reset_dout: got %h expected 0", ifc.dout_local); end
    nChecks++; if (ifc.pv_local !== '0) begin nErrors++; $display("FAIL reset_pv: got %h expected 0", ifc.pv_local); end
    nChecks++; if (ifc.starve_req !== 1'b0) begin nErrors++; $display("FAIL reset_starve: got %b expected 0", ifc.starve_req); end
    nChecks++; if (ifc.fifo_cnt !== '0) begin nErrors++; $display("FAIL reset_cnt: got %0d expected 0", ifc.fifo_cnt); end
    modelClear();
    reset = 1'b1;
    #1;
    nChecks++; if (ifc.pe_ready !== 1'b1) begin nErrors++; $display("FAIL reset_ready: got %b expected 1", ifc.pe_ready); end
  endtask

  task automatic test_single_push();
    logic [FW-1:0] f;
    f = randFlit();
    ifc.pe_flit = f; ifc.pe_pv = 5'b00100; ifc.pe_valid = 1; ifc.slot_free = 1;
    tick();
    nChecks++; if (ifc.fifo_cnt !== 1) begin nErrors++; $display("FAIL single_cnt1: got %0d expected 1", ifc.fifo_cnt); end
    nChecks++; if (ifc.dout_local !== '0) begin nErrors++; $display("FAIL single_nobypass: got %h expected 0", ifc.dout_local); end
    ifc.pe_valid = 0;
    tick();
    nChecks++; if (ifc.dout_local !== f) begin nErrors++; $display("FAIL single_dout: got %h expected %h", ifc.dout_local, f); end
    nChecks++; if (ifc.pv_local !== 5'b00100) begin nErrors++; $display("FAIL single_pv: got %b expected 00100", ifc.pv_local); end
    tick();
    nChecks++; if (ifc.dout_local !== '0) begin nErrors++; $display("FAIL single_idle: got %h expected 0", ifc.dout_local); end
    nChecks++; if (ifc.fifo_cnt !== 0) begin nErrors++; $display("FAIL single_cnt0: got %0d expected 0", ifc.fifo_cnt); end
  endtask

  task automatic test_fill();
    ifc.slot_free = 0;
    for (int i = 0; i < D; i++) begin
      ifc.pe_flit = randFlit(); ifc.pe_pv = PW'($urandom); ifc.pe_valid = 1;
      tick();
    end
    nChecks++; if (ifc.fifo_cnt !== D) begin nErrors++; $display("FAIL fill_cnt: got %0d expected %0d", ifc.fifo_cnt, D); end
    nChecks++; if (ifc.pe_ready !== 1'b0) begin nErrors++; $display("FAIL fill_ready: got %b expected 0", ifc.pe_ready); end
    ifc.pe_flit = randFlit(); ifc.pe_pv = PW'($urandom);
    tick();
    nChecks++; if (ifc.fifo_cnt !== D) begin nErrors++; $display("FAIL fill_fifth: got %0d expected %0d", ifc.fifo_cnt, D); end
    ifc.pe_valid = 0; ifc.slot_free = 1;
    for (int i = 0; i < D; i++) begin
      tick();
      nChecks++; if (ifc.dout_local !== expDout || ifc.pv_local !== expPv) begin
        nErrors++; $display("FAIL fill_out%0d: got %h/%h expected %h/%h", i, ifc.dout_local, ifc.pv_local, expDout, expPv);
      end
      if (i == 0) begin
        nChecks++; if (ifc.pe_ready !== 1'b1) begin nErrors++; $display("FAIL fill_ready_back: got %b expected 1", ifc.pe_ready); end
      end
    end
    tick();
    nChecks++; if (ifc.dout_local !== '0) begin nErrors++; $display("FAIL fill_drained: got %h expected 0", ifc.dout_local); end
  endtask

  task automatic test_starve();
    ifc.pe_flit = randFlit(); ifc.pe_pv = PW'($urandom); ifc.pe_valid = 1; ifc.slot_free = 0;
    tick();
    ifc.pe_valid = 0;
    for (int k = 1; k <= LIM; k++) begin
      tick();
      nChecks++; if (ifc.starve_req !== (k >= LIM)) begin
        nErrors++; $display("FAIL starve_blocked%0d: got %b expected %b", k, ifc.starve_req, (k >= LIM));
      end
    end
    ifc.slot_free = 1;
    tick();
    nChecks++; if (ifc.dout_local !== expDout) begin nErrors++; $display("FAIL starve_inject: got %h expected %h", ifc.dout_local, expDout); end
    nChecks++; if (ifc.starve_req !== 1'b0) begin nErrors++; $display("FAIL starve_drop: got %b expected 0", ifc.starve_req); end
    nChecks++; if (dut.state !== INJ_IDLE) begin nErrors++; $display("FAIL starve_idle: got %0d expected %0d", dut.state, INJ_IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] sent[20];
    logic [FW-1:0] got[$];
    int idx = 0;
    for (int i = 0; i < 20; i++) sent[i] = randFlit();
    for (int cyc = 0; cyc < 400 && got.size() < 20; cyc++) begin
      ifc.pe_valid = (idx < 20);
      if (idx < 20) begin ifc.pe_flit = sent[idx]; ifc.pe_pv = PW'(idx); end
      ifc.slot_free = (cyc % 2 == 0);
      if (ifc.pe_valid && mq.size() != D) idx++;
      tick();
      nChecks++; if (ifc.dout_local !== expDout) begin nErrors++; $display("FAIL b2b_dout: got %h expected %h", ifc.dout_local, expDout); end
      nChecks++; if (ifc.fifo_cnt > D) begin nErrors++; $display("FAIL b2b_cnt: got %0d expected <= %0d", ifc.fifo_cnt, D); end
      if (ifc.dout_local[POS_VALID]) got.push_back(ifc.dout_local);
    end
    ifc.pe_valid = 0;
    nChecks++; if (got.size() != 20) begin nErrors++; $display("FAIL b2b_count: got %0d expected 20", got.size()); end
    for (int i = 0; i < got.size() && i < 20; i++) begin
      nChecks++; if (got[i] !== sent[i]) begin nErrors++; $display("FAIL b2b_order%0d: got %h expected %h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_random();
    int pct[6] = '{50, 5, 90, 0, 30, 100};
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 50; c++) begin
        ifc.pe_valid  = ($urandom_range(0, 99) < 60);
        ifc.pe_flit   = randFlit();
        ifc.pe_pv     = PW'($urandom);
        ifc.slot_free = ($urandom_range(0, 99) < pct[blk]);
        tick();
        nChecks++; if (ifc.dout_local !== expDout || ifc.pv_local !== expPv) begin
          nErrors++; $display("FAIL rand_out: got %h/%h expected %h/%h", ifc.dout_local, ifc.pv_local, expDout, expPv);
        end
        nChecks++; if (ifc.starve_req !== expStarve) begin nErrors++; $display("FAIL rand_starve: got %b expected %b", ifc.starve_req, expStarve); end
        nChecks++; if (ifc.fifo_cnt !== mq.size() || ifc.pe_ready !== (mq.size() != D)) begin
          nErrors++; $display("FAIL rand_cnt: got %0d/%b expected %0d/%b", ifc.fifo_cnt, ifc.pe_ready, mq.size(), (mq.size() != D));
        end
      end
    end
`ifdef INJ_CTRL_STATS_EN
    nChecks++; if (ifc.stat_inj !== 16'(mInj) || ifc.stat_stall !== 16'(mStall)) begin
      nErrors++; $display("FAIL rand_stats: got %0d/%0d expected %0d/%0d", ifc.stat_inj, ifc.stat_stall, mInj, mStall);
    end
`endif
    ifc.pe_valid = 0; ifc.slot_free = 1;
    repeat (D + 1) tick();
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    ifc.slot_free = 0; ifc.pe_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ifc.pe_flit = randFlit(); ifc.pe_pv = PW'($urandom);
      tick();
    end
    ifc.pe_valid = 0;
    while (!expStarve && guard < 40) begin tick(); guard++; end
    nChecks++; if (ifc.starve_req !== 1'b1 || ifc.fifo_cnt !== 3) begin
      nErrors++; $display("FAIL mid_setup: got starve %b cnt %0d expected 1 and 3", ifc.starve_req, ifc.fifo_cnt);
    end
    #2 reset = 1'b0;
    #1;
    nChecks++; if (ifc.starve_req !== 1'b0) begin nErrors++; $display("FAIL mid_starve: got %b expected 0", ifc.starve_req); end
    nChecks++; if (ifc.fifo_cnt !== 0) begin nErrors++; $display("FAIL mid_cnt: got %0d expected 0", ifc.fifo_cnt); end
    nChecks++; if (ifc.dout_local !== '0 || ifc.pv_local !== '0) begin nErrors++; $display("FAIL mid_dout: got %h/%h expected 0", ifc.dout_local, ifc.pv_local); end
    modelClear();
    @(posedge clk);
    #1 reset = 1'b1;
    ifc.slot_free = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      nChecks++; if (ifc.dout_local !== '0 || ifc.fifo_cnt !== 0) begin
        nErrors++; $display("FAIL mid_stale%0d: got %h cnt %0d expected 0", i, ifc.dout_local, ifc.fifo_cnt);
      end
    end
  endtask

`ifdef INJ_CTRL_STATS_EN
  task automatic test_stats();
    ifc.pe_valid = 0; ifc.slot_free = 0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    modelClear();
    ifc.pe_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ifc.pe_flit = randFlit(); ifc.pe_pv = PW'($urandom);
      tick();
    end
    ifc.pe_valid = 0;
    repeat (5) tick();
    ifc.slot_free = 1;
    repeat (3) tick();
    nChecks++; if (ifc.stat_inj !== 16'd3) begin nErrors++; $display("FAIL stats_inj: got %0d expected 3", ifc.stat_inj); end
    nChecks++; if (ifc.stat_stall !== 16'd7) begin nErrors++; $display("FAIL stats_stall: got %0d expected 7", ifc.stat_stall); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_starve();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef INJ_CTRL_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
